// File: rtl/minimac2_rxcheck.sv
// Reads a received RX slot back over the MAC's Wishbone RAM port, checks the
// CRC-32 residue and classifies the destination address. One byte per cycle.
module minimac2_rxcheck #(
  parameter logic [31:0] wb_base = 32'h0000_0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        slot,
  input  logic [10:0] count,
  input  logic [47:0] mac_addr,
  input  logic        promisc,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic        addr_match,
  output logic        bcast,
  output logic        mcast,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  typedef enum logic [1:0] {IDLE, READ, CRC, FIN} state_t;

  state_t      state_q, state_d;
  logic        slot_q, slot_d;
  logic [10:0] count_q, count_d;
  logic [10:0] idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] crc_q, crc_d;
  logic        uhit_q, uhit_d;
  logic        bhit_q, bhit_d;
  logic        mc_q, mc_d;
  logic        crc_ok_q, crc_ok_d;
  logic        match_q, match_d;
  logic        bcast_q, bcast_d;
  logic        mcast_q, mcast_d;
  logic [7:0]  cur_byte;
  logic [7:0]  mac_byte;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Byte lanes are big-endian: frame offset 0 of each word sits on [31:24].
  always_comb begin
    cur_byte = 8'h00;
    case (idx_q[1:0])
      2'd0: cur_byte = word_q[31:24];
      2'd1: cur_byte = word_q[23:16];
      2'd2: cur_byte = word_q[15:8];
      2'd3: cur_byte = word_q[7:0];
      default: cur_byte = 8'h00;
    endcase
    mac_byte = 8'h00;
    case (idx_q[2:0])
      3'd0: mac_byte = mac_addr[47:40];
      3'd1: mac_byte = mac_addr[39:32];
      3'd2: mac_byte = mac_addr[31:24];
      3'd3: mac_byte = mac_addr[23:16];
      3'd4: mac_byte = mac_addr[15:8];
      3'd5: mac_byte = mac_addr[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    count_d  = count_q;
    idx_d    = idx_q;
    word_d   = word_q;
    crc_d    = crc_q;
    uhit_d   = uhit_q;
    bhit_d   = bhit_q;
    mc_d     = mc_q;
    crc_ok_d = crc_ok_q;
    match_d  = match_q;
    bcast_d  = bcast_q;
    mcast_d  = mcast_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          crc_ok_d = 1'b0;
          match_d  = 1'b0;
          bcast_d  = 1'b0;
          mcast_d  = 1'b0;
          if (count == 11'd0) begin
            state_d = FIN;
          end else begin
            slot_d  = slot;
            count_d = count;
            idx_d   = 11'd0;
            crc_d   = 32'hFFFF_FFFF;
            uhit_d  = 1'b1;
            bhit_d  = 1'b1;
            mc_d    = 1'b0;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (wbm_ack_i) begin
          word_d  = wbm_dat_i;
          state_d = CRC;
        end
      end
      CRC: begin
        crc_d = crc_step(crc_q, cur_byte);
        idx_d = idx_q + 11'd1;
        if (idx_q < 11'd6) begin
          uhit_d = uhit_q & (cur_byte == mac_byte);
          bhit_d = bhit_q & (cur_byte == 8'hFF);
          if (idx_q == 11'd0) mc_d = cur_byte[0];
        end
        if (idx_d == count_q) begin
          state_d  = FIN;
          crc_ok_d = (crc_d == CRC_RESIDUE);
          // Too short to hold a full destination: only promiscuous mode can accept it.
          if (count_q < 11'd6) begin
            match_d = promisc;
            bcast_d = 1'b0;
            mcast_d = 1'b0;
          end else begin
            bcast_d = bhit_d;
            mcast_d = mc_d & ~bhit_d;
            match_d = promisc | uhit_d | bhit_d;
          end
        end else if (idx_q[1:0] == 2'd3) begin
          state_d = READ;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      slot_q   <= 1'b0;
      count_q  <= 11'd0;
      idx_q    <= 11'd0;
      word_q   <= 32'h0;
      crc_q    <= 32'h0;
      uhit_q   <= 1'b0;
      bhit_q   <= 1'b0;
      mc_q     <= 1'b0;
      crc_ok_q <= 1'b0;
      match_q  <= 1'b0;
      bcast_q  <= 1'b0;
      mcast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      crc_q    <= crc_d;
      uhit_q   <= uhit_d;
      bhit_q   <= bhit_d;
      mc_q     <= mc_d;
      crc_ok_q <= crc_ok_d;
      match_q  <= match_d;
      bcast_q  <= bcast_d;
      mcast_q  <= mcast_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign crc_ok     = crc_ok_q;
  assign addr_match = match_q;
  assign bcast      = bcast_q;
  assign mcast      = mcast_q;
  assign wbm_cyc_o  = (state_q == READ);
  assign wbm_stb_o  = (state_q == READ);
  assign wbm_we_o   = 1'b0;
  assign wbm_sel_o  = 4'hF;
  assign wbm_adr_o  = (state_q == READ)
                    ? wb_base + {20'h0, slot_q, 11'h0} + {21'h0, idx_q[10:2], 2'b00}
                    : 32'h0;

endmodule
